scan_counter_display: RTL and testbench
=======================================

SCAN_COUNTER_DISPLAY -- requirements
Module: scan_counter_display

Interface
REQ-001 Parameter N_DIGITS, default 4: number of 7-segment digits; legal range 1..8.
REQ-002 Parameter DB_CYCLES, default 250000: number of consecutive stable clocks that qualifies a button level.
REQ-003 Parameter SCAN_CYCLES, default 50000: dwell time in clocks per digit during anode scanning.
REQ-004 clock  input  1  single system clock; all state is clocked on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_up  input  1  raw asynchronous push-button, active-high; increments the count.
REQ-007 btn_down  input  1  raw asynchronous push-button, active-high; decrements the count.
REQ-008 dec_mode  input  1  count format: 0 = hex, each digit 0..F; 1 = BCD, each digit 0..9.
REQ-009 leds  output  8  count[7:0]; bits above COUNT_W read as 0.
REQ-010 segOutput  output  8  active-low segment pattern: bit 7 = dp, bits 6:0 = g..a.
REQ-011 anodes  output  N_DIGITS  active-low one-hot digit enable.

Function
REQ-012 COUNT_W SHALL equal 4*N_DIGITS; the count is held in a COUNT_W-bit register.
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-014 Debounce SHALL be a 4-state FSM per button: IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE.
  - IDLE -> WAIT_PRESS when the synchronized level is 1.
  - WAIT_PRESS -> PRESSED after DB_CYCLES consecutive 1s; any 0 returns the FSM to IDLE.
  - PRESSED -> WAIT_RELEASE when the synchronized level is 0.
  - WAIT_RELEASE -> IDLE after DB_CYCLES consecutive 0s; any 1 returns the FSM to PRESSED.
REQ-015 The WAIT_PRESS -> PRESSED transition SHALL emit exactly one 1-cycle pulse; holding the button SHALL NOT auto-repeat.
REQ-016 The count SHALL update on the clock after the pulse, so raw edge to count change is DB_CYCLES+3 clocks.
REQ-017 Up pulse alone: count+1. Down pulse alone: count-1. Both pulses in the same cycle: count unchanged.
REQ-018 Hex mode SHALL wrap modulo 2^COUNT_W in both directions.
REQ-019 BCD mode SHALL count 0..10^N_DIGITS-1 with per-digit carry and borrow.
  - Up from all-9s wraps to 0.
  - Down from 0 wraps to all-9s.
REQ-020 Any change of dec_mode SHALL clear the count to 0 on the next clock; a pulse in that same cycle SHALL be discarded.
REQ-021 A scan counter SHALL advance the active digit every SCAN_CYCLES clocks, in order 0,1,...,N_DIGITS-1,0.
REQ-022 Digit 0 SHALL be the least-significant nibble, with anodes[0] low.
REQ-023 segOutput SHALL be the registered decode of the active digit's nibble, aligned in the same cycle as anodes.
  - Hex decode: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - dp SHALL always be 1 (off).
REQ-024 Exactly one anodes bit SHALL be low at all times after reset.

Reset
REQ-025 While reset_n=0, all state SHALL clear asynchronously.
  - count = 0, both debounce FSMs = IDLE, synchronizers = 0, scan digit = 0, scan counter = 0.
  - Outputs: leds=00, anodes = all-ones except bit 0 = 0, segOutput = C0.
REQ-026 Reset asserted mid-debounce or mid-scan SHALL emit no pulse; the count SHALL be 0 on the first clock after release.
REQ-027 Reset deassertion SHALL be synchronized to clock internally (2-flop); the first state change is allowed on the 2nd clock after release.

Structure
REQ-028 A shared package SHALL hold the 16-entry segment table, the debounce state encoding, and the default parameter constants.
REQ-029 Debounce SHALL be one sub-module, debounce_pulse (synchronizer + FSM + pulse), instantiated twice.
REQ-030 Counter, BCD arithmetic and scan/decode SHALL live in scan_counter_display.

Verification (N_DIGITS=2, DB_CYCLES=4, SCAN_CYCLES=3)
REQ-031 Clean btn_up press held 20 clocks -> exactly one pulse; count 00->01 at clock DB_CYCLES+3 after the edge; leds=01.
REQ-032 btn_up glitches 1/0 every 2 clocks for 30 clocks -> no pulse; count stays 00.
REQ-033 Hex mode, count=00, one btn_down -> FF; one btn_up -> 00. BCD mode, count=99, one btn_up -> 00.
REQ-034 btn_up and btn_down pulses in the same cycle at count=42 -> count stays 42.
REQ-035 Count=3A, hex mode, run 12 clocks -> anodes sequence 10,01,10,01 with 3-clock dwell; segOutput alternates 88 and B0.
REQ-036 Assert reset_n=0 during WAIT_PRESS with count=07 -> outputs go to reset values immediately; no increment after release.

Source files
------------

// File: rtl/scan_counter_display_pkg.sv
// Shared definitions for the scanned 7-segment up/down counter: segment table,
// debounce state encoding and default parameter values.
package scan_counter_display_pkg;

    localparam int DEF_N_DIGITS    = 4;
    localparam int DEF_DB_CYCLES   = 250000;
    localparam int DEF_SCAN_CYCLES = 50000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } db_state_e;

    // Active-low patterns {dp, g..a}; entry 0 is the rightmost element.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] seg_decode(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/scan_counter_display_debounce_pulse.sv
// Button conditioner: 2-flop synchronizer, 4-state debounce FSM and a single
// registered pulse on each qualified press.
module debounce_pulse
    import scan_counter_display_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync;
    logic             level;
    db_state_e        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             pulse_next;

    assign level = sync[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            state <= IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            state <= state_next;
            cnt   <= cnt_next;
            pulse <= pulse_next;
        end
    end

    // The level seen on entering a wait state is already the first of the
    // DB_CYCLES stable samples, hence the counter starts at one.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        state_next = state;
        cnt_next   = cnt;
        pulse_next = 1'b0;
        case (state)
            IDLE: begin
                if (level) begin
                    state_next = WAIT_PRESS;
                    cnt_next   = CNT_ONE;
                end
            end
            WAIT_PRESS: begin
                if (!level) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt >= DB_LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!level) begin
                    state_next = WAIT_RELEASE;
                    cnt_next   = CNT_ONE;
                end
            end
            WAIT_RELEASE: begin
                if (level) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt >= DB_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/scan_counter_display.sv
// Debounced up/down counter (hex or BCD) shown on a multiplexed, active-low
// 7-segment display with one digit enabled at a time.
module scan_counter_display
    import scan_counter_display_pkg::*;
#(
    parameter int N_DIGITS    = DEF_N_DIGITS,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int SCAN_CYCLES = DEF_SCAN_CYCLES
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                dec_mode,
    output logic [7:0]          leds,
    output logic [7:0]          segOutput,
    output logic [N_DIGITS-1:0] anodes
);

    localparam int COUNT_W = 4 * N_DIGITS;
    localparam int DIGIT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SCAN_W  = $clog2(SCAN_CYCLES + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(N_DIGITS - 1);

    logic [1:0]          rst_pipe;
    logic                rst_n;
    logic                up_pulse, down_pulse;
    logic                mode_q;
    logic [COUNT_W-1:0]  count, count_next;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [DIGIT_W-1:0]  digit;
    logic [3:0]          nibble;
    logic [7:0]          seg_q;
    logic [N_DIGITS-1:0] anodes_q;

    // Reset asserts immediately but releases two clocks later, in step with clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clock  (clock),
        .reset_n(rst_n),
        .btn    (btn_up),
        .pulse  (up_pulse)
    );

    debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_down (
        .clock  (clock),
        .reset_n(rst_n),
        .btn    (btn_down),
        .pulse  (down_pulse)
    );

    // Ripple carry/borrow across BCD digits; all-9s and all-0s wrap naturally.
    function automatic logic [COUNT_W-1:0] bcd_step(input logic [COUNT_W-1:0] value,
                                                   input logic              down);
        logic [COUNT_W-1:0] r;
        logic               carry;
        r     = value;
        carry = 1'b1;
        for (int d = 0; d < N_DIGITS; d++) begin
            if (carry) begin
                if (!down) begin
                    if (r[4*d +: 4] == 4'd9) r[4*d +: 4] = 4'd0;
                    else begin
                        r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (r[4*d +: 4] == 4'd0) r[4*d +: 4] = 4'd9;
                    else begin
                        r[4*d +: 4] = r[4*d +: 4] - 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        count_next = count;
        if (dec_mode != mode_q) begin
            count_next = '0;
        end else if (up_pulse && !down_pulse) begin
            count_next = dec_mode ? bcd_step(count, 1'b0) : count + 1'b1;
        end else if (down_pulse && !up_pulse) begin
            count_next = dec_mode ? bcd_step(count, 1'b1) : count - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            mode_q <= 1'b0;
        end else begin
            count  <= count_next;
            mode_q <= dec_mode;
        end
    end

    assign nibble = 4'(count >> {digit, 2'b00});

    // Anodes and segments are registered together so they change in the same cycle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            digit    <= '0;
            anodes_q <= ~N_DIGITS'(1);
            seg_q    <= seg_decode(4'd0);
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                digit    <= (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            anodes_q <= ~(N_DIGITS'(1) << digit);
            seg_q    <= seg_decode(nibble);
        end
    end

    assign leds      = 8'(count);
    assign segOutput = seg_q;
    assign anodes    = anodes_q;

endmodule

// File: tb/tb_scan_counter_display.sv
// Directed bench for scan_counter_display with a 2-digit, fast-debounce,
// fast-scan configuration.
module tb_scan_counter_display;

    localparam int N_DIGITS    = 2;
    localparam int DB_CYCLES   = 4;
    localparam int SCAN_CYCLES = 3;

    typedef struct {
        logic       mode;
        logic       up;
        logic       down;
        logic [7:0] leds;
        logic [7:0] seg_lo;
        logic [7:0] seg_hi;
    } vec_t;

    logic                clock = 1'b0;
    logic                reset_n;
    logic                btn_up;
    logic                btn_down;
    logic                dec_mode;
    logic [7:0]          leds;
    logic [7:0]          segOutput;
    logic [N_DIGITS-1:0] anodes;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    vec_t vecs[16];

    always #5 clock = ~clock;

    scan_counter_display #(
        .N_DIGITS   (N_DIGITS),
        .DB_CYCLES  (DB_CYCLES),
        .SCAN_CYCLES(SCAN_CYCLES)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .dec_mode (dec_mode),
        .leds     (leds),
        .segOutput(segOutput),
        .anodes   (anodes)
    );

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic up, input logic down);
        btn_up   = up;
        btn_down = down;
        tick(DB_CYCLES + 6);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(DB_CYCLES + 6);
    endtask

    // Toggling the mode twice clears the count and leaves the mode unchanged.
    task automatic clear_count();
        dec_mode = ~dec_mode;
        tick(2);
        dec_mode = ~dec_mode;
        tick(2);
    endtask

    task automatic check_display(input string name, input logic [7:0] lo, input logic [7:0] hi);
        logic seen_lo = 1'b0;
        logic seen_hi = 1'b0;
        for (int i = 0; i < 4 * N_DIGITS * SCAN_CYCLES && !(seen_lo && seen_hi); i++) begin
            @(negedge clock);
            if (anodes == 2'b10 && !seen_lo) begin
                check({name, " seg digit0"}, segOutput, lo);
                seen_lo = 1'b1;
            end else if (anodes == 2'b01 && !seen_hi) begin
                check({name, " seg digit1"}, segOutput, hi);
                seen_hi = 1'b1;
            end
        end
        check({name, " both digits scanned"}, {6'b0, seen_hi, seen_lo}, 8'h03);
    endtask

    initial begin
        logic [1:0] prev;
        logic [1:0] cur;
        logic [1:0] exp_an;
        logic       found;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h8E, 8'h8E};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hC0, 8'hC0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'h01, 8'hF9, 8'hC0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h01, 8'hF9, 8'hC0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'hC0, 8'hC0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 8'h8E, 8'h8E};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'hFE, 8'h86, 8'h8E};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'hFD, 8'hA1, 8'h8E};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'hFC, 8'hC6, 8'h8E};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'hFB, 8'h83, 8'h8E};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h99, 8'h90, 8'h90};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h98, 8'h80, 8'h90};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 8'h99, 8'h90, 8'h90};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'hC0, 8'hC0};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h99, 8'h90, 8'h90};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h01, 8'hF9, 8'hC0};

        reset_n  = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        dec_mode = 1'b0;
        tick(3);
        check("reset leds", leds, 8'h00);
        check("reset anodes", {6'b0, anodes}, 8'h02);
        check("reset seg", segOutput, 8'hC0);
        reset_n = 1'b1;
        tick(4);

        // Glitching button: high 2 clocks, low 2 clocks, never stable long enough.
        for (int i = 0; i < 30; i++) begin
            btn_up = ((i >> 1) & 1) == 0;
            tick(1);
        end
        btn_up = 1'b0;
        tick(DB_CYCLES + 6);
        check("glitch no count", leds, 8'h00);

        // Clean press: count changes exactly DB_CYCLES+3 clocks after the edge.
        btn_up = 1'b1;
        tick(DB_CYCLES + 2);
        check("press before latency", leds, 8'h00);
        tick(1);
        check("press at latency", leds, 8'h01);
        tick(13);
        check("press held no repeat", leds, 8'h01);
        btn_up = 1'b0;
        tick(DB_CYCLES + 6);
        check("press after release", leds, 8'h01);

        clear_count();
        check("mode toggle clears", leds, 8'h00);

        foreach (vecs[i]) begin
            if (dec_mode != vecs[i].mode) begin
                dec_mode = vecs[i].mode;
                tick(2);
            end
            press(vecs[i].up, vecs[i].down);
            check($sformatf("vec%0d leds", i), leds, vecs[i].leds);
            check_display($sformatf("vec%0d", i), vecs[i].seg_lo, vecs[i].seg_hi);
        end

        // Mode change in the very cycle the count would step: pulse is dropped.
        btn_up = 1'b1;
        tick(DB_CYCLES + 2);
        check("mode race before", leds, 8'h01);
        dec_mode = 1'b1;
        tick(1);
        check("mode race cleared", leds, 8'h00);
        tick(5);
        check("mode race pulse dropped", leds, 8'h00);
        btn_up = 1'b0;
        tick(DB_CYCLES + 6);
        dec_mode = 1'b0;
        tick(2);
        check("back to hex cleared", leds, 8'h00);

        for (int i = 0; i < 8'h3A; i++) press(1'b1, 1'b0);
        check("count to 3A", leds, 8'h3A);

        prev  = anodes;
        found = 1'b0;
        for (int i = 0; i < 4 * SCAN_CYCLES && !found; i++) begin
            tick(1);
            if (anodes != prev) found = 1'b1;
        end
        check("scan transition seen", {7'b0, found}, 8'h01);
        cur = anodes;
        check("scan phase one-hot", {7'b0, (cur == 2'b01) || (cur == 2'b10)}, 8'h01);
        for (int i = 0; i < 12; i++) begin
            exp_an = (((i / SCAN_CYCLES) % 2) == 0) ? cur : ~cur;
            check($sformatf("scan anodes t%0d", i), {6'b0, anodes}, {6'b0, exp_an});
            check($sformatf("scan seg t%0d", i), segOutput, (exp_an == 2'b10) ? 8'h88 : 8'hB0);
            tick(1);
        end

        for (int i = 0; i < 8; i++) press(1'b1, 1'b0);
        check("count to 42", leds, 8'h42);
        check_display("count 42", 8'hA4, 8'h99);
        press(1'b1, 1'b1);
        check("both buttons at 42", leds, 8'h42);

        clear_count();
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0);
        check("count to 07", leds, 8'h07);
        check_display("count 07", 8'hF8, 8'hC0);

        // Reset in the middle of a debounce wait.
        btn_up = 1'b1;
        tick(4);
        #2 reset_n = 1'b0;
        #1;
        check("mid-debounce reset leds", leds, 8'h00);
        check("mid-debounce reset anodes", {6'b0, anodes}, 8'h02);
        check("mid-debounce reset seg", segOutput, 8'hC0);
        btn_up = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(DB_CYCLES + 10);
        check("no count after reset", leds, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
